// File: rtl/multififo_reader.sv
// multififo_reader: drains a multi-port FIFO in batches of up to four words
// into a staging ring, then streams the ring out one word per cycle.
module multififo_reader #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SDEPTH  = 8,
  parameter int unsigned BATCH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      softreset,
  input  logic [15:0]               fifo_count,
  output logic [2:0]                reads,
  input  logic [WIDTH*4-1:0]        fifo_dout,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(SDEPTH):0]   stage_count,
  output logic                      timer_expired
);

  localparam int unsigned PW = $clog2(SDEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] ring [SDEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [15:0]      timer;
  logic [15:0]      stage_free;
  logic [15:0]      avail;
  logic             pop;

  // Words that can be read now: limited by port count, FIFO occupancy and ring space
  always_comb begin
    stage_free = 16'(SDEPTH) - 16'(stage_count);
    avail      = 16'd4;
    if (fifo_count < avail) avail = fifo_count;
    if (stage_free < avail) avail = stage_free;
  end

  assign timer_expired = (timer >= 16'(TIMEOUT));

  // Issue a read only for a full batch, or a partial one when flushed or starved
  always_comb begin
    reads = 3'd0;
    if (rst_n && !softreset && (avail != 16'd0) &&
        ((avail >= 16'(BATCH)) || flush || timer_expired))
      reads = 3'(avail);
  end

  assign out_valid = (stage_count != CW'(0));
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? ring[head] : '0;

  // Capture the returned lanes into consecutive ring slots starting at tail
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < reads)
        ring[PW'(tail + PW'(k))] <= fifo_dout[k*WIDTH +: WIDTH];
    end
  end

  // Ring pointers, occupancy and saturating starvation timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      stage_count <= '0;
      timer       <= '0;
    end else if (softreset) begin
      head        <= '0;
      tail        <= '0;
      stage_count <= '0;
      timer       <= '0;
    end else begin
      tail        <= tail + PW'(reads);
      if (pop) head <= head + PW'(1);
      stage_count <= stage_count + CW'(reads) - CW'(pop);
      if ((reads != 3'd0) || (fifo_count == 16'd0))
        timer <= '0;
      else if (timer != 16'hFFFF)
        timer <= timer + 16'd1;
    end
  end

endmodule

// File: tb/tb_multififo_reader.sv
// Bench for multififo_reader: FIFO source model, ordered scoreboard,
// a per-cycle vector table and hand-written multi-cycle sequences.
module tb_multififo_reader;

  logic         clk;
  logic         rst_n;
  logic         softreset;
  logic [15:0]  fifo_count;
  logic [2:0]   reads;
  logic [127:0] fifo_dout;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [3:0]   stage_count;
  logic         timer_expired;

  multififo_reader #(.WIDTH(32), .SDEPTH(8), .BATCH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .softreset(softreset), .fifo_count(fifo_count),
    .reads(reads), .fifo_dout(fifo_dout), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .stage_count(stage_count),
    .timer_expired(timer_expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         npush;
    logic       fl;
    logic       rdy;
    logic       sr;
    logic [2:0] rd;
    logic       vld;
    logic [3:0] cnt;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] src[$];
  logic [31:0] exp_q[$];
  int          next_word;
  int          checks;
  int          errors;
  logic [2:0]  s_reads;
  logic        s_valid;
  logic [3:0]  s_count;
  logic        s_texp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input int np, input int fl, input int rdy, input int sr,
                              input int rd, input int vld, input int cnt);
    vec_t v;
    v.npush = np; v.fl = 1'(fl); v.rdy = 1'(rdy); v.sr = 1'(sr);
    v.rd = 3'(rd); v.vld = 1'(vld); v.cnt = 4'(cnt);
    tbl.push_back(v);
  endfunction

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      src.push_back(32'hA500_0000 + 32'(next_word));
      next_word++;
    end
  endtask

  // One clock cycle, entered and left at the falling edge
  task automatic cycle(input int npush, input logic fl, input logic rdy, input logic sr);
    push(npush);
    flush      = fl;
    out_ready  = rdy;
    softreset  = sr;
    fifo_count = 16'(src.size());
    fifo_dout  = '0;
    #1;
    for (int k = 0; k < 4; k++)
      if (k < int'(reads) && k < src.size()) fifo_dout[k*32 +: 32] = src[k];
    #1;
    s_reads = reads;
    s_valid = out_valid;
    s_count = stage_count;
    s_texp  = timer_expired;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 32'(out_valid), 32'd0);
      else chk("order", out_data, exp_q.pop_front());
    end else if (!out_valid) begin
      chk("data_idle", out_data, 32'd0);
    end
    for (int k = 0; k < int'(reads); k++)
      if (src.size() > 0) exp_q.push_back(src.pop_front());
    if (sr) exp_q.delete();
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && (out_valid || src.size() > 0); i++) cycle(0, 1'b0, 1'b1, 1'b0);
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_scoreboard", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic random_drain(input string tag);
    for (int i = 0; i < 400 && (src.size() > 0 || stage_count != 4'd0); i++)
      cycle(0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    chk({tag, "_src_empty"}, 32'(src.size()), 32'd0);
    chk({tag, "_scoreboard"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_count"}, 32'(stage_count), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; next_word = 0;
    rst_n = 1'b0; softreset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    fifo_dout = '0;
    push(10);
    fifo_count = 16'(src.size());

    // Reset held with words waiting in the FIFO
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_reads", 32'(reads), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_count", 32'(stage_count), 32'd0);
    chk("rst_texp", 32'(timer_expired), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // push, flush, ready, softreset, exp reads, exp valid, exp count
    add(0, 0, 0, 0, 4, 0, 0);
    add(0, 0, 1, 0, 4, 1, 4);
    add(0, 0, 1, 0, 0, 1, 7);
    add(0, 0, 1, 0, 0, 1, 6);
    add(0, 0, 1, 0, 0, 1, 5);
    add(0, 0, 1, 0, 0, 1, 4);
    add(0, 0, 1, 0, 0, 1, 3);
    add(0, 0, 1, 0, 0, 1, 2);
    add(0, 0, 1, 0, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 3, 0, 0);
    add(0, 0, 0, 0, 0, 1, 3);
    add(2, 1, 0, 0, 2, 1, 3);
    add(8, 0, 0, 1, 0, 1, 5);
    add(0, 0, 0, 0, 4, 0, 0);
    add(0, 0, 1, 0, 4, 1, 4);
    add(0, 0, 1, 0, 0, 1, 7);
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].npush, tbl[i].fl, tbl[i].rdy, tbl[i].sr);
      chk($sformatf("tbl%0d_reads", i), 32'(s_reads), 32'(tbl[i].rd));
      chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_count", i), 32'(s_count), 32'(tbl[i].cnt));
    end
    drain();

    // Starvation timer: two words wait 16 idle cycles, then get read
    for (int t = 0; t < 18; t++) begin
      cycle((t == 0) ? 2 : 0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("timer%0d_reads", t), 32'(s_reads), (t == 16) ? 32'd2 : 32'd0);
      chk($sformatf("timer%0d_texp", t), 32'(s_texp), (t == 16) ? 32'd1 : 32'd0);
    end
    chk("timer_count_after", 32'(s_count), 32'd2);
    drain();

    // Downstream stall fills the ring; reads resume after four pops
    for (int s = 0; s < 5; s++) begin
      cycle((s == 0) ? 20 : 0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("stall%0d_reads", s), 32'(s_reads), (s < 2) ? 32'd4 : 32'd0);
      chk($sformatf("stall%0d_count", s), 32'(s_count), (s == 0) ? 32'd0 : (s == 1) ? 32'd4 : 32'd8);
    end
    for (int r = 0; r < 5; r++) begin
      cycle(0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("resume%0d_reads", r), 32'(s_reads), (r == 4) ? 32'd4 : 32'd0);
      chk($sformatf("resume%0d_count", r), 32'(s_count), 32'(8 - r));
    end
    random_drain("stall");

    // Wrap: 13 more words with random backpressure
    push(13);
    random_drain("wrap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
